// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI4-Lite definitions for the bridge and its interface.
package axi_pkg;
    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_DATA_WIDTH = 32;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WRESP,
        RADDR,
        RDATA
    } axil_state_e;
endpackage

// File: rtl/axi_intf.sv
// axi_intf: AXI4-Lite channel bundle with master and slave views.
interface axi_intf #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input logic aclk
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic                  rvalid;
    logic                  rready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;

    modport master (
        input  aclk,
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  aclk,
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axil_master_bridge.sv
// axil_master_bridge: turns the core's single-request memory port into
// AXI4-Lite master transactions with one transaction in flight.
module axil_master_bridge
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = AXI_ADDR_WIDTH,
    parameter int DATA_WIDTH = AXI_DATA_WIDTH,
    localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
    axi_intf.master                 axi,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [STRB_WIDTH-1:0]   req_wstrb,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err
);
    axil_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  accept, aw_hs, w_hs, b_done, r_done;

    always_ff @(posedge axi.aclk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = req_valid ? (req_we ? WRITE : RADDR) : IDLE;
            WRITE:   state_d = ((aw_done_q || aw_hs) && (w_done_q || w_hs)) ? WRESP : WRITE;
            WRESP:   state_d = axi.bvalid ? IDLE : WRESP;
            RADDR:   state_d = axi.arready ? RDATA : RADDR;
            RDATA:   state_d = axi.rvalid ? IDLE : RDATA;
            default: state_d = IDLE;
        endcase
    end

    // AXI payloads come only from the latched request so they stay stable while valid.
    always_comb begin
        req_ready   = state_q == IDLE;
        axi.awvalid = state_q == WRITE && !aw_done_q;
        axi.wvalid  = state_q == WRITE && !w_done_q;
        axi.bready  = state_q == WRESP;
        axi.arvalid = state_q == RADDR;
        axi.rready  = state_q == RDATA;
        axi.awaddr  = addr_q;
        axi.araddr  = addr_q;
        axi.wdata   = wdata_q;
        axi.wstrb   = wstrb_q;
        rsp_valid   = rsp_valid_q;
        rsp_err     = rsp_err_q;
        rsp_rdata   = rdata_q;
    end

    always_comb begin
        accept      = state_q == IDLE && req_valid;
        aw_hs       = axi.awvalid && axi.awready;
        w_hs        = axi.wvalid && axi.wready;
        b_done      = state_q == WRESP && axi.bvalid;
        r_done      = state_q == RDATA && axi.rvalid;
        addr_d      = accept ? req_addr : addr_q;
        wdata_d     = accept ? req_wdata : wdata_q;
        wstrb_d     = accept ? req_wstrb : wstrb_q;
        aw_done_d   = state_q == WRITE && (aw_done_q || aw_hs);
        w_done_d    = state_q == WRITE && (w_done_q || w_hs);
        rsp_valid_d = b_done || r_done;
        rsp_err_d   = b_done ? axi.bresp != AXI_RESP_OKAY :
                      r_done ? axi.rresp != AXI_RESP_OKAY : rsp_err_q;
        rdata_d     = r_done ? axi.rdata : rdata_q;
    end

    always_ff @(posedge axi.aclk or posedge rst) begin
        if (rst) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rdata_q     <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rdata_q     <= rdata_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
        end
    end
endmodule

// File: tb/tb_axil_master_bridge.sv
// tb_axil_master_bridge: directed scoreboard bench with a configurable-latency AXI-Lite slave.
module tb_axil_master_bridge;
    import axi_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, rsp_valid, rsp_err;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [3:0]  req_wstrb;

    always #5 clk = ~clk;

    axi_intf #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi (.aclk(clk));

    axil_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .axi       (axi),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          errors = 0, checks = 0;
    int          aw_delay = 0, w_delay = 0, ar_delay = 0, r_delay = 0, b_delay = 0;
    logic [31:0] rdata_v = 32'h0;
    logic [1:0]  rresp_v = 2'b00, bresp_v = 2'b00;
    int          aw_cnt, w_cnt, ar_cnt, r_cnt, b_cnt, w_beats, aw_hi, w_hi;
    logic        aw_got, w_got, b_pend, r_pend;
    logic [31:0] aw_cap, w_cap;
    logic [3:0]  led;

    always_comb begin
        axi.awready = axi.awvalid && aw_cnt >= aw_delay;
        axi.wready  = axi.wvalid && w_cnt >= w_delay;
        axi.arready = axi.arvalid && ar_cnt >= ar_delay;
        axi.bvalid  = b_pend && b_cnt >= b_delay;
        axi.bresp   = bresp_v;
        axi.rvalid  = r_pend && r_cnt >= r_delay;
        axi.rdata   = rdata_v;
        axi.rresp   = rresp_v;
    end

    // Slave model: counts wait cycles per channel, LED register lives at 0xFF.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; r_cnt <= 0; b_cnt <= 0;
            aw_got <= 0; w_got <= 0; b_pend <= 0; r_pend <= 0;
        end else begin
            aw_cnt <= (axi.awvalid && !axi.awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (axi.wvalid && !axi.wready) ? w_cnt + 1 : 0;
            ar_cnt <= (axi.arvalid && !axi.arready) ? ar_cnt + 1 : 0;
            if (axi.awvalid) aw_hi <= aw_hi + 1;
            if (axi.wvalid) w_hi <= w_hi + 1;
            if (axi.awvalid && axi.awready) begin aw_got <= 1; aw_cap <= axi.awaddr; end
            if (axi.wvalid && axi.wready) begin w_got <= 1; w_cap <= axi.wdata; w_beats <= w_beats + 1; end
            if ((aw_got || (axi.awvalid && axi.awready)) && (w_got || (axi.wvalid && axi.wready))) begin
                aw_got <= 0;
                w_got  <= 0;
                b_pend <= 1;
                if ((aw_got ? aw_cap : axi.awaddr) == 32'hFF)
                    led <= aw_got ? w_cap[3:0] : axi.wdata[3:0];
                if (!w_got) w_cap <= axi.wdata;
                if (!aw_got) aw_cap <= axi.awaddr;
            end
            if (b_pend) b_cnt <= axi.bvalid ? b_cnt : b_cnt + 1;
            if (axi.bvalid && axi.bready) begin b_pend <= 0; b_cnt <= 0; end
            if (axi.arvalid && axi.arready) r_pend <= 1;
            if (r_pend) r_cnt <= axi.rvalid ? r_cnt : r_cnt + 1;
            if (axi.rvalid && axi.rready) begin r_pend <= 0; r_cnt <= 0; end
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    exp_t me;
    int   ma;
    int   rsp_seen = 0, last_rsp_cyc = -1, last_wait = 0, last_acc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            rsp_seen++;
            last_rsp_cyc = cyc;
            if (exp_q.size() == 0 || acc_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rsp_valid at cycle %0d expected none", cyc);
            end else begin
                me = exp_q.pop_front();
                ma = acc_q.pop_front();
                check("rsp_err", 64'(rsp_err), 64'(me.err));
                check("rsp_rdata", 64'(rsp_rdata), 64'(me.rdata));
                check("rsp_latency", 64'(cyc - ma), 64'(me.lat));
            end
        end
    end

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic [31:0] exp_rd, input logic exp_err,
                         input int exp_lat, input bit track);
        req_valid = 1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
        last_wait = 0;
        while (!req_ready && last_wait < 100) begin
            @(negedge clk);
            last_wait++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got req_ready=0 expected 1 within 100 cycles");
        end else begin
            last_acc = cyc;
            if (track) begin
                exp_q.push_back('{exp_rd, exp_err, exp_lat});
                acc_q.push_back(cyc);
            end
        end
        @(negedge clk);
        req_valid = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
            acc_q.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int aw0, w0, wb0, rs0, n;
        rst = 1; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
        w_beats = 0; aw_hi = 0; w_hi = 0; led = 0; aw_cap = 0; w_cap = 0;
        repeat (3) @(negedge clk);
        check("reset_req_ready", 64'(req_ready), 64'(1));
        check("reset_awvalid", 64'(axi.awvalid), 64'(0));
        check("reset_arvalid", 64'(axi.arvalid), 64'(0));
        check("reset_bready", 64'(axi.bready), 64'(0));
        check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        check("reset_rsp_rdata", 64'(rsp_rdata), 64'(0));
        check("reset_rsp_err", 64'(rsp_err), 64'(0));
        rst = 0;
        @(negedge clk);

        issue(1, 32'hFF, 32'hA, 4'hF, 32'h0, 0, 3, 1);
        wait_idle();
        check("led_awaddr", 64'(aw_cap), 64'(32'hFF));
        check("led_wdata", 64'(w_cap), 64'(32'hA));
        check("led_value", 64'(led), 64'(4'hA));

        aw_delay = 2;
        aw0 = aw_hi; w0 = w_hi; wb0 = w_beats; rs0 = rsp_seen;
        issue(1, 32'h10, 32'h55, 4'hF, 32'h0, 0, 5, 1);
        wait_idle();
        aw_delay = 0;
        check("split_awvalid_cycles", 64'(aw_hi - aw0), 64'(3));
        check("split_wvalid_cycles", 64'(w_hi - w0), 64'(1));
        check("split_w_beats", 64'(w_beats - wb0), 64'(1));
        check("split_rsp_count", 64'(rsp_seen - rs0), 64'(1));

        ar_delay = 1; r_delay = 2; rdata_v = 32'hDEAD_BEEF;
        issue(0, 32'h100, 32'h0, 4'h0, 32'hDEAD_BEEF, 0, 6, 1);
        check("wait_arvalid_c1", 64'(axi.arvalid), 64'(1));
        check("wait_araddr_c1", 64'(axi.araddr), 64'(32'h100));
        @(negedge clk);
        check("wait_arvalid_c2", 64'(axi.arvalid), 64'(1));
        check("wait_araddr_c2", 64'(axi.araddr), 64'(32'h100));
        wait_idle();
        ar_delay = 0; r_delay = 0;

        rdata_v = 32'h1234; rresp_v = AXI_RESP_SLVERR;
        issue(0, 32'h104, 32'h0, 4'h0, 32'h1234, 1, 3, 1);
        wait_idle();
        rdata_v = 32'hCAFE_0001; rresp_v = AXI_RESP_OKAY;
        issue(0, 32'h108, 32'h0, 4'h0, 32'hCAFE_0001, 0, 3, 1);
        wait_idle();

        rdata_v = 32'h5555_AAAA;
        issue(1, 32'h20, 32'h77, 4'hF, 32'hCAFE_0001, 0, 3, 1);
        issue(0, 32'h24, 32'h0, 4'h0, 32'h5555_AAAA, 0, 3, 1);
        check("b2b_busy_cycles", 64'(last_wait), 64'(2));
        check("b2b_accept_on_rsp", 64'(last_acc), 64'(last_rsp_cyc));
        wait_idle();

        b_delay = 20; rs0 = rsp_seen;
        issue(1, 32'h30, 32'h1, 4'hF, 32'h0, 0, 0, 0);
        n = 0;
        while (!axi.bready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rst_reached_wresp", 64'(axi.bready), 64'(1));
        #2 rst = 1;
        #1;
        check("rst_bready", 64'(axi.bready), 64'(0));
        check("rst_awvalid", 64'(axi.awvalid), 64'(0));
        check("rst_wvalid", 64'(axi.wvalid), 64'(0));
        check("rst_arvalid", 64'(axi.arvalid), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 0; b_delay = 0;
        check("rst_req_ready", 64'(req_ready), 64'(1));
        repeat (5) @(negedge clk);
        check("rst_no_rsp", 64'(rsp_seen - rs0), 64'(0));

        rdata_v = 32'h0BAD_F00D;
        issue(0, 32'h40, 32'h0, 4'h0, 32'h0BAD_F00D, 0, 3, 1);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
